// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver: finds byte alignment from comma symbols and
// delivers aligned data bytes with a valid flag, all in the bit-rate domain.
module serial_paralelo_rx #(
    parameter logic [7:0]  COMMA  = 8'hBC,
    parameter int unsigned BC_REQ = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active,
    output logic       byte_strobe
);

    typedef enum logic [1:0] {
        StBuscando,
        StContando,
        StSincronizado
    } state_e;

    localparam logic [3:0] BcReq = 4'(BC_REQ);

    state_e     state_q;
    logic [7:0] sr_q;
    logic [2:0] bit_cnt_q;
    logic [3:0] bc_cnt_q;
    logic [7:0] nxt;
    logic       boundary;
    logic       is_comma;

    assign nxt      = {sr_q[6:0], data_in};
    assign boundary = (bit_cnt_q == 3'd7);
    assign is_comma = (nxt == COMMA);

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_q     <= StBuscando;
            sr_q        <= 8'h00;
            bit_cnt_q   <= 3'd0;
            bc_cnt_q    <= 4'd0;
            data_out    <= 8'h00;
            valid_out   <= 1'b0;
            active      <= 1'b0;
            byte_strobe <= 1'b0;
        end else begin
            sr_q        <= nxt;
            byte_strobe <= 1'b0;
            case (state_q)
                StBuscando: begin
                    // Bit-level search: any position may start a comma.
                    if (is_comma) begin
                        bit_cnt_q <= 3'd0;
                        bc_cnt_q  <= 4'd1;
                        if (BcReq == 4'd1) begin
                            state_q <= StSincronizado;
                            active  <= 1'b1;
                        end else begin
                            state_q <= StContando;
                        end
                    end
                end
                StContando: begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (boundary) begin
                        if (is_comma) begin
                            bc_cnt_q <= bc_cnt_q + 4'd1;
                            if (bc_cnt_q + 4'd1 == BcReq) begin
                                state_q <= StSincronizado;
                                active  <= 1'b1;
                            end
                        end else begin
                            bc_cnt_q <= 4'd0;
                            state_q  <= StBuscando;
                        end
                    end
                end
                StSincronizado: begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (boundary) begin
                        byte_strobe <= 1'b1;
                        if (is_comma) begin
                            valid_out <= 1'b0;
                        end else begin
                            data_out  <= nxt;
                            valid_out <= 1'b1;
                        end
                    end
                end
                default: state_q <= StBuscando;
            endcase
        end
    end

endmodule
